// File: rtl/cprv_dmem_if.sv
// Request/response channel pair between the mem stage and the data memory.
// The master is the mem stage; the slave is cprv_dmem.
interface cprv_dmem_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7
);
   logic                  valid_dmem_i;
   logic                  ready_dmem_o;
   logic [ADDR_WIDTH-1:0] addr_dmem_i;
   logic [DATA_WIDTH-1:0] wdata_dmem_i;
   logic                  w_en_dmem_i;
   logic                  valid_mem_dmem_o;
   logic                  ready_mem_dmem_i;
   logic [DATA_WIDTH-1:0] rdata_dmem_o;

   modport master (
      output valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
      input  ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o
   );

   modport slave (
      input  valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
      output ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o
   );
endinterface

// File: rtl/cprv_dmem.sv
// Word-addressed data memory with one outstanding request and a fixed
// request-to-response latency; stores commit at the acceptance edge.
module cprv_dmem #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7,
   parameter int LATENCY    = 1
) (
   input logic         clk,
   input logic         rst_n,
   cprv_dmem_if.slave  dmem
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("cprv_dmem: LATENCY must be in 1..15");
   end

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   state_e                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  accept;

   // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
   assign accept = dmem.valid_dmem_i & ready_q;

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               rdata_d = dmem.w_en_dmem_i ? dmem.wdata_dmem_i : mem[dmem.addr_dmem_i];
               ready_d = 1'b0;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  valid_d = 1'b1;
               end else begin
                  cnt_d   = LAT_M1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               valid_d = 1'b1;
            end
         end
         RESP: begin
            if (dmem.ready_mem_dmem_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // The array has no reset; reset only blocks a write in the same cycle.
   always_ff @(posedge clk) begin
      if (rst_n && accept && dmem.w_en_dmem_i) begin
         mem[dmem.addr_dmem_i] <= dmem.wdata_dmem_i;
      end
   end

   assign dmem.ready_dmem_o     = ready_q;
   assign dmem.valid_mem_dmem_o = valid_q;
   assign dmem.rdata_dmem_o     = rdata_q;

endmodule
